f3m_mult_serial: RTL

- Digit-serial multiplier over GF(3^M), parametrised in field degree, irreducible polynomial and digits per cycle.
- Computes C = A*B mod P, or C = A*B + C_prev mod P when accumulate is requested.
- Built on the GF(3) trit primitives (add, sub, mult) as the sequential successor to them.
- Serves as the shared field-multiply engine for the pairing datapath in place of wide combinational multipliers.

---
 rtl/f3m_mult_serial.sv | 131 +++++++++++++
 1 files changed

// File: rtl/f3m_mult_serial.sv
// Digit-serial GF(3^M) multiplier: C = A*B mod P, optionally + previous C.
// A is consumed MSB-first, D trits per cycle, using Horner's scheme on acc.
module f3m_mult_serial #(
  parameter int M = 97,
  parameter int D = 1,
  parameter logic [2*(M+1)-1:0] PX = 196'h4000000000000000000000000000000000000000001000002
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accumulate,
  input  logic [2*M-1:0]   a,
  input  logic [2*M-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [2*M-1:0]   c
);

  localparam int S  = (M + D - 1) / D;
  localparam int AW = 2 * S * D;
  localparam int CW = $clog2(S + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] a_reg;
  logic [2*M-1:0] b_reg;
  logic [2*M-1:0] acc;
  logic [2*M-1:0] cold;
  logic          acc_flag;
  logic [CW-1:0] cnt;

  logic [2*M-1:0] step;
  logic [2*M-1:0] sh;
  logic [2*M-1:0] sum;
  logic [1:0]     t;
  logic [1:0]     ai;

  function automatic logic [1:0] t_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Negation mod 3 swaps the codes 01 and 10.
  function automatic logic [1:0] t_sub(input logic [1:0] x, input logic [1:0] y);
    return t_add(x, {y[0], y[1]});
  endfunction

  function automatic logic [1:0] t_mul(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] r;
    if (x == 2'd0 || y == 2'd0) r = 2'd0;
    else if (x == 2'd1)         r = y;
    else if (y == 2'd1)         r = x;
    else                        r = 2'd1;
    return r;
  endfunction

  // One MULT cycle: D Horner steps, acc = acc*x mod P + a_i*B per trit.
  always_comb begin
    step = acc;
    sh   = '0;
    t    = '0;
    ai   = '0;
    for (int unsigned j = 0; j < D; j++) begin
      ai = a_reg[AW-1-2*j -: 2];
      t  = step[2*M-1 -: 2];
      sh = {step[2*M-3:0], 2'b00};
      for (int unsigned k = 0; k < M; k++) begin
        step[2*k +: 2] = t_add(t_sub(sh[2*k +: 2], t_mul(t, PX[2*k +: 2])),
                               t_mul(ai, b_reg[2*k +: 2]));
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < M; k++) begin
      sum[2*k +: 2] = t_add(acc[2*k +: 2], cold[2*k +: 2]);
    end
  end

  assign busy = (state == MULT) || (state == ADD);
  assign done = (state == DONE);

  // c is loaded on the ADD->DONE edge so it is visible during the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cold     <= '0;
      acc_flag <= 1'b0;
      cnt      <= '0;
      c        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg    <= AW'(a);
            b_reg    <= b;
            acc_flag <= accumulate;
            cold     <= c;
            acc      <= '0;
            cnt      <= CW'(S);
            state    <= MULT;
          end else begin
            state <= IDLE;
          end
        end
        MULT: begin
          acc   <= step;
          a_reg <= a_reg << (2 * D);
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ADD;
        end
        ADD: begin
          acc   <= acc_flag ? sum : acc;
          c     <= acc_flag ? sum : acc;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
